// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encodings and the default operand width.
package mdu_iter_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULTU = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_DIVU  = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// 2*WIDTH-bit accumulator ({upper partial, lower multiplier/quotient}).
module mdu_step
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (div_mode) begin
            // Borrow out of the trial subtraction means restore (keep the shifted remainder).
            if (!trial[WIDTH])
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; the FIX cycle applies sign correction.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), exact when read as unsigned.
    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = is_signed & A[WIDTH-1];
    assign b_neg     = is_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_mode),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next)
    );

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op <= MDU_DIV) begin
                            // Lower half holds multiplier (mult) or dividend (div).
                            acc      <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                            opnd     <= op[1] ? b_mag : a_mag;
                            a_orig   <= A;
                            div_mode <= op[1];
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= op[1] && (B == '0);
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= S_RUN;
                        end else if (op == MDU_MTHI) begin
                            HI <= A;
                        end else if (op == MDU_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (div_mode) begin
                        if (div_zero) begin
                            HI <= a_orig;
                            LO <= '1;
                        end else begin
                            HI <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            LO <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        end
                    end else begin
                        {HI, LO} <= neg_q ? -acc : acc;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: table vectors, random ops against a
// behavioural model, and hand-written sequences for MT/ignore/reset cases.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cycles = 0;
    logic busy_q = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
        exp_t e;
        logic signed [63:0] p;
        logic signed [W-1:0] sa, sbv;
        sa = ma;
        sbv = mb;
        e.hi = '0;
        e.lo = '0;
        case (mop)
            MDU_MULTU: {e.hi, e.lo} = {32'b0, ma} * {32'b0, mb};
            MDU_MULT: begin
                p = 64'(sa) * 64'(sbv);
                {e.hi, e.lo} = p;
            end
            MDU_DIVU: begin
                if (mb == 0) begin e.hi = ma; e.lo = '1; end
                else begin e.lo = ma / mb; e.hi = ma % mb; end
            end
            default: begin
                if (mb == 0) begin e.hi = ma; e.lo = '1; end
                else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin e.hi = '0; e.lo = 32'h8000_0000; end
                else begin e.lo = sa / sbv; e.hi = sa % sbv; end
            end
        endcase
        return e;
    endfunction

    // Scoreboard side: measures busy length and compares HI/LO when busy falls.
    always @(negedge clk) begin
        if (rst) begin
            busy_cycles = 0;
            busy_q = 1'b0;
        end else begin
            if (busy) busy_cycles++;
            if (busy_q && !busy) begin
                check("busy_len", 64'(busy_cycles), 64'(W + 1));
                check("sb_pending", 64'(sbq.size()), 64'd1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("result_hi", 64'(hi), 64'(e.hi));
                    check("result_lo", 64'(lo), 64'(e.lo));
                end
                busy_cycles = 0;
            end
            busy_q = busy;
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk); #1;
        end
        check(name, 64'(busy), 64'd0);
        @(negedge clk); #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb, input exp_t e);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = va; b = vb;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        wait_idle("op_done");
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vecs[0] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MDU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        foreach (vecs[i]) begin
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        // DIV by zero with negative dividend keeps the original signed A in HI.
        e.hi = 32'hFFFF_FF00; e.lo = 32'hFFFF_FFFF;
        run_op(MDU_DIV, 32'hFFFF_FF00, 32'd0, e);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (ro[1] && (i % 2 == 1)) rb = $urandom_range(1, 1000);
            run_op(ro, ra, rb, model(ro, ra, rb));
        end

        // MTHI then MTLO on back-to-back cycles.
        @(posedge clk); #1;
        start = 1'b1; op = MDU_MTHI; a = 32'h1234_5678;
        @(posedge clk); #1;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'd0);
        op = MDU_MTLO; a = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mtlo_hi", 64'(hi), 64'h1234_5678);
        check("mtlo_busy", 64'(busy), 64'd0);

        // MTLO arriving while busy is dropped.
        start = 1'b1; op = MDU_MULTU; a = 32'd6; b = 32'd7;
        e.hi = 32'd0; e.lo = 32'd42;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = MDU_MTLO; a = 32'h0000_DEAD;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_lo_hold", 64'(lo), 64'h9ABC_DEF0);
        check("ign_busy", 64'(busy), 64'd1);
        wait_idle("ign_done");
        check("ign_lo_final", 64'(lo), 64'd42);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        start = 1'b1; op = MDU_MULTU; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        check("abort_stays_lo", 64'(lo), 64'd0);

        e.hi = 32'd1; e.lo = 32'd2;
        run_op(MDU_DIVU, 32'd9, 32'd4, e);

        // Reserved op is ignored.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_hi", 64'(hi), 64'd1);
        check("rsvd_lo", 64'(lo), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Sits directly downstream of the register file.
- Consumes RF read data (RD1 -> A, RD2 -> B) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its HI/LO outputs return to the RF write-data mux for MFHI/MFLO.
- Main-pipeline control stalls on busy.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH bits each. Iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request strobe; sampled on posedge when busy=0.
- op  in  3  operation select: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved.
- A  in  WIDTH  operand A / multiplicand / dividend / MT source.
- B  in  WIDTH  operand B / multiplier / divisor.
- busy  out  1  high while an iterative operation is in flight.
- HI  out  WIDTH  HI register: product upper half, or remainder.
- LO  out  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Clock, reset: one clock clk. Synchronous active-high reset rst.
- Reset values: busy=0, HI=0, LO=0, FSM in IDLE, iteration counter 0.
- Reset mid-operation aborts the operation; no partial result ever reaches HI/LO.
- FSM has three states: IDLE, RUN, FIX.
- IDLE, start=1, op in {0..3}:
  - latch operands. For signed ops, latch magnitudes and the result-sign flags.
  - clear the counter; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4 (MTHI) or op=5 (MTLO):
  - HI<=A (MTHI) or LO<=A (MTLO) at that edge; busy stays 0.
  - single-cycle; the FSM stays in IDLE.
- IDLE, start=1, op in {6,7}: ignored; no state change.
- start while busy=1: ignored entirely, including MTHI/MTLO. Upstream must hold the request until busy=0.
- RUN: one radix-2 step per cycle, WIDTH cycles total.
  - multiply: shift-add.
  - divide: restoring, 2*WIDTH-bit remainder/quotient register.
  - after step WIDTH-1, go to FIX.
- FIX: one cycle.
  - apply sign correction: product negated if sign(A)^sign(B); quotient negated if sign(A)^sign(B); remainder takes sign of A.
  - write HI/LO at this edge; busy falls at the same edge; return to IDLE.
- Latency: start sampled at edge t -> HI/LO updated and busy=0 after edge t+WIDTH+1.
  - busy is high for exactly WIDTH+1 cycles.
  - HI/LO keep their old values throughout RUN/FIX. Work registers are internal.
- Divide by zero (B=0), DIVU and DIV: LO=all ones, HI=A (original signed A for DIV). Full latency still applies.
- Signed overflow, DIV of -2^(WIDTH-1) by -1: LO=0x80000000, HI=0. No exception.
- Magnitude of -2^(WIDTH-1) is handled in WIDTH+1 bits or as unsigned, so no truncation occurs.
- Unsigned ops ignore sign flags; FIX passes through unchanged.
- Outputs HI, LO, busy are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - op encoding constants MDU_MULTU=3'd0 .. MDU_MTLO=3'd5;
  - FSM state encodings S_IDLE, S_RUN, S_FIX;
  - the WIDTH default.
- One natural sub-module: mdu_step, purely combinational. It performs one radix-2 iteration for either mode, taking the accumulator/partial register and returning its next value.
- Top level holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then next cycle MTLO A=0x9ABCDEF0 -> HI/LO updated one edge after each; busy never asserts.
- Start MULTU 6*7; at cycle 5 of RUN pulse start with MTLO A=0xDEAD -> MTLO ignored, result HI=0, LO=42. Repeat the multiply and assert rst at cycle 10 -> busy=0, HI=LO=0 next cycle; subsequent DIVU 9/4 -> LO=2, HI=1.
